// File: rtl/mbist_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mbist_mem_responder_pkg
// Shared definitions for the MBIST memory responder and its fault table:
//   - flt_type_e : fault-entry type encodings (none, stuck-at-0, stuck-at-1,
//                  up-transition fault)
//   - WRITE/READ : encodings of the write_read access qualifier
//   - sat_inc()  : 16-bit saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package mbist_mem_responder_pkg;

   typedef enum logic [1:0] {
      FLT_NONE  = 2'd0,
      FLT_SA0   = 2'd1,
      FLT_SA1   = 2'd2,
      FLT_TF_UP = 2'd3
   } flt_type_e;

   localparam logic WRITE = 1'b1;
   localparam logic READ  = 1'b0;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == CNT_MAX) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mbist_fault_table.sv
// -----------------------------------------------------------------------------
// mbist_fault_table
// Programmable table of injected memory faults. Each entry holds a type, a
// word address and a bit position. For the address currently being accessed
// it produces one-hot-per-bit masks of the active stuck-at-0, stuck-at-1 and
// up-transition faults.
// Ports:
//   clk, rst_n       clock / synchronous active-low reset (clears all types)
//   flt_wr           entry write strobe; new contents are visible next cycle
//   flt_idx          entry index to write
//   flt_type         entry type (flt_type_e encoding)
//   flt_addr         faulty word address
//   flt_bit          faulty bit position
//   lookup_addr      address of the current access
//   sa0_mask         bits forced to 0 on read
//   sa1_mask         bits forced to 1 on read
//   tfup_mask        bits that cannot make a 0->1 transition on write
// -----------------------------------------------------------------------------
module mbist_fault_table
   import mbist_mem_responder_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   parameter  int ADDR_WIDTH = 16,
   parameter  int NUM_FAULTS = 4,
   localparam int IDX_W      = $clog2(NUM_FAULTS),
   localparam int BIT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flt_wr,
   input  logic [IDX_W-1:0]      flt_idx,
   input  logic [1:0]            flt_type,
   input  logic [ADDR_WIDTH-1:0] flt_addr,
   input  logic [BIT_W-1:0]      flt_bit,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   output logic [DATA_WIDTH-1:0] sa0_mask,
   output logic [DATA_WIDTH-1:0] sa1_mask,
   output logic [DATA_WIDTH-1:0] tfup_mask
);

   flt_type_e             ent_type [NUM_FAULTS];
   logic [ADDR_WIDTH-1:0] ent_addr [NUM_FAULTS];
   logic [BIT_W-1:0]      ent_bit  [NUM_FAULTS];

   // Winning fault type for every data bit of the looked-up word.
   flt_type_e             bit_type [DATA_WIDTH];

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FAULTS; i++) begin
            ent_type[i] <= FLT_NONE;
         end
      end else if (flt_wr) begin
         ent_type[flt_idx] <= flt_type_e'(flt_type);
      end
   end

   // Address and bit are only meaningful while the type is non-zero, so
   // they carry no reset.
   always_ff @(posedge clk) begin
      if (flt_wr) begin
         ent_addr[flt_idx] <= flt_addr;
         ent_bit[flt_idx]  <= flt_bit;
      end
   end

   // Walk from the highest index down so the lowest matching index is the
   // last writer of a given bit and therefore wins. Entries on different
   // bits never collide and all apply.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update;
      // a path that leaves one unassigned would infer a latch.
      for (int b = 0; b < DATA_WIDTH; b++) begin
         bit_type[b] = FLT_NONE;
      end
      sa0_mask  = '0;
      sa1_mask  = '0;
      tfup_mask = '0;
      for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
         if (ent_type[i] != FLT_NONE && ent_addr[i] == lookup_addr) begin
            bit_type[ent_bit[i]] = ent_type[i];
         end
      end
      for (int b = 0; b < DATA_WIDTH; b++) begin
         sa0_mask[b]  = (bit_type[b] == FLT_SA0);
         sa1_mask[b]  = (bit_type[b] == FLT_SA1);
         tfup_mask[b] = (bit_type[b] == FLT_TF_UP);
      end
   end

endmodule

// File: rtl/mbist_mem_responder.sv
// -----------------------------------------------------------------------------
// mbist_mem_responder
// Memory-side model for an MBIST controller: a single-port word array with a
// programmable fault table (SA0, SA1, TF_UP) applied to its accesses.
// Ports:
//   clk, rst_n      clock / synchronous active-low reset
//   mem_en          access strobe, one access per cycle while high
//   write_read      1 = write, 0 = read
//   address         word address (>= MEM_DEPTH is out of range)
//   wdata           write data
//   rdata           registered read data, held between reads
//   rvalid          one-cycle pulse: rdata updated by a read
//   oor_err         one-cycle pulse: previous access was out of range
//   flt_wr..flt_bit fault-table programming port
//   read_cnt        saturating count of in-range reads
//   fault_hit_cnt   saturating count of reads whose data a fault altered
// -----------------------------------------------------------------------------
module mbist_mem_responder
   import mbist_mem_responder_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   parameter  int ADDR_WIDTH = 16,
   parameter  int MEM_DEPTH  = 256,
   parameter  int NUM_FAULTS = 4,
   localparam int IDX_W      = $clog2(NUM_FAULTS),
   localparam int BIT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_en,
   input  logic                  write_read,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  oor_err,
   input  logic                  flt_wr,
   input  logic [IDX_W-1:0]      flt_idx,
   input  logic [1:0]            flt_type,
   input  logic [ADDR_WIDTH-1:0] flt_addr,
   input  logic [BIT_W-1:0]      flt_bit,
   output logic [15:0]           read_cnt,
   output logic [15:0]           fault_hit_cnt
);

   localparam int                  MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is still representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [MEM_AW-1:0]     mem_idx;
   logic                  in_range;
   logic                  is_wr;
   logic                  is_rd;
   logic [DATA_WIDTH-1:0] stored;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] sa0_mask;
   logic [DATA_WIDTH-1:0] sa1_mask;
   logic [DATA_WIDTH-1:0] tfup_mask;

   mbist_fault_table #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_FAULTS (NUM_FAULTS)
   ) u_fault_table (
      .clk         (clk),
      .rst_n       (rst_n),
      .flt_wr      (flt_wr),
      .flt_idx     (flt_idx),
      .flt_type    (flt_type),
      .flt_addr    (flt_addr),
      .flt_bit     (flt_bit),
      .lookup_addr (address),
      .sa0_mask    (sa0_mask),
      .sa1_mask    (sa1_mask),
      .tfup_mask   (tfup_mask)
   );

   assign in_range = ({1'b0, address} < DEPTH_L);
   assign mem_idx  = address[MEM_AW-1:0];
   assign is_wr    = mem_en && (write_read == WRITE);
   assign is_rd    = mem_en && (write_read == READ);
   assign stored   = mem[mem_idx];

   // TF_UP: a faulty bit currently 0 cannot be written to 1; 1->0 passes.
   assign wr_word  = wdata & ~(tfup_mask & ~stored);
   // Lowest-index resolution guarantees SA0 and SA1 never share a bit.
   assign rd_word  = (stored & ~sa0_mask) | sa1_mask;

   // NOTE: the array is deliberately left out of reset; resetting it would
   // turn an inferable RAM into a huge flop bank with a reset tree.
   always_ff @(posedge clk) begin
      if (rst_n && is_wr && in_range) begin
         mem[mem_idx] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata         <= '0;
         rvalid        <= 1'b0;
         oor_err       <= 1'b0;
         read_cnt      <= '0;
         fault_hit_cnt <= '0;
      end else begin
         rvalid  <= is_rd;
         oor_err <= mem_en && !in_range;
         if (is_rd) begin
            if (in_range) begin
               rdata    <= rd_word;
               read_cnt <= sat_inc(read_cnt);
               if (rd_word != stored) begin
                  fault_hit_cnt <= sat_inc(fault_hit_cnt);
               end
            end else begin
               rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mbist_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mbist_mem_responder
// Directed bench for mbist_mem_responder with default parameters
// (64-bit data, 16-bit address, 256 words, 4 fault entries).
// -----------------------------------------------------------------------------
module tb_mbist_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_en;
   logic        write_read;
   logic [15:0] address;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        rvalid;
   logic        oor_err;
   logic        flt_wr;
   logic [1:0]  flt_idx;
   logic [1:0]  flt_type;
   logic [15:0] flt_addr;
   logic [5:0]  flt_bit;
   logic [15:0] read_cnt;
   logic [15:0] fault_hit_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [63:0] PAT3 = 64'hFFFF_0000_AAAA_5555;

   mbist_mem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_en        (mem_en),
      .write_read    (write_read),
      .address       (address),
      .wdata         (wdata),
      .rdata         (rdata),
      .rvalid        (rvalid),
      .oor_err       (oor_err),
      .flt_wr        (flt_wr),
      .flt_idx       (flt_idx),
      .flt_type      (flt_type),
      .flt_addr      (flt_addr),
      .flt_bit       (flt_bit),
      .read_cnt      (read_cnt),
      .fault_hit_cnt (fault_hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access captured at the next rising edge; outputs settle #1 later.
   task automatic access(input logic we, input logic [15:0] a, input logic [63:0] d);
      @(negedge clk);
      mem_en     = 1'b1;
      write_read = we;
      address    = a;
      wdata      = d;
      @(posedge clk);
      #1;
      mem_en = 1'b0;
      flt_wr = 1'b0;
   endtask

   // Stage a fault-table write; it is issued with the next access/idle edge.
   task automatic stage_flt(input logic [1:0] idx, input logic [1:0] ty,
                            input logic [15:0] a, input logic [5:0] b);
      flt_wr   = 1'b1;
      flt_idx  = idx;
      flt_type = ty;
      flt_addr = a;
      flt_bit  = b;
   endtask

   task automatic idle();
      @(negedge clk);
      mem_en = 1'b0;
      @(posedge clk);
      #1;
      flt_wr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_en = 1'b0; write_read = 1'b0; address = '0; wdata = '0;
      flt_wr = 1'b0; flt_idx = '0; flt_type = '0; flt_addr = '0; flt_bit = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdata", rdata, 64'h0);
      check("rst_rvalid", rvalid, 64'h0);
      check("rst_oor", oor_err, 64'h0);
      check("rst_read_cnt", read_cnt, 64'h0);
      check("rst_fault_cnt", fault_hit_cnt, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Plain write then read
      access(1'b1, 16'd3, PAT3);
      check("wr_no_rvalid", rvalid, 64'h0);
      access(1'b0, 16'd3, 64'h0);
      check("rd3_data", rdata, PAT3);
      check("rd3_rvalid", rvalid, 64'h1);
      check("rd3_read_cnt", read_cnt, 64'd1);
      check("rd3_oor", oor_err, 64'h0);
      idle();
      check("idle_rvalid", rvalid, 64'h0);
      check("idle_hold", rdata, PAT3);

      // SA1 at addr 5 bit 0
      stage_flt(2'd0, 2'd2, 16'd5, 6'd0);
      access(1'b1, 16'd5, 64'h0);
      access(1'b0, 16'd5, 64'h0);
      check("sa1_data", rdata, 64'h1);
      check("sa1_hit_cnt", fault_hit_cnt, 64'd1);
      // Clear in the same cycle as a read: that read still sees the old table
      stage_flt(2'd0, 2'd0, 16'd5, 6'd0);
      access(1'b0, 16'd5, 64'h0);
      check("clr_same_cycle", rdata, 64'h1);
      check("clr_same_hit", fault_hit_cnt, 64'd2);
      access(1'b0, 16'd5, 64'h0);
      check("clr_next_data", rdata, 64'h0);
      check("clr_next_hit", fault_hit_cnt, 64'd2);
      check("clr_read_cnt", read_cnt, 64'd4);

      // TF_UP at addr 7 bit 63
      access(1'b1, 16'd7, 64'h0);
      stage_flt(2'd1, 2'd3, 16'd7, 6'd63);
      idle();
      access(1'b1, 16'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      access(1'b0, 16'd7, 64'h0);
      check("tfup_up_blocked", rdata, 64'h7FFF_FFFF_FFFF_FFFF);
      check("tfup_no_hit", fault_hit_cnt, 64'd2);
      // 1->0 must still succeed with the fault active
      stage_flt(2'd1, 2'd0, 16'd7, 6'd63);
      idle();
      access(1'b1, 16'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      stage_flt(2'd1, 2'd3, 16'd7, 6'd63);
      idle();
      access(1'b1, 16'd7, 64'h0);
      access(1'b0, 16'd7, 64'h0);
      check("tfup_down_ok", rdata, 64'h0);

      // Out-of-range accesses
      access(1'b1, 16'd0, 64'hA5A5_A5A5_0000_1111);
      access(1'b1, 16'd256, 64'h1234);
      check("oor_wr_err", oor_err, 64'h1);
      check("oor_wr_rvalid", rvalid, 64'h0);
      access(1'b0, 16'd300, 64'h0);
      check("oor_rd_data", rdata, 64'h0);
      check("oor_rd_rvalid", rvalid, 64'h1);
      check("oor_rd_err", oor_err, 64'h1);
      check("oor_rd_cnt", read_cnt, 64'd6);
      idle();
      check("oor_pulse_end", oor_err, 64'h0);
      access(1'b0, 16'd0, 64'h0);
      check("oor_wr_dropped", rdata, 64'hA5A5_A5A5_0000_1111);
      check("boundary_255_ok", {63'h0, oor_err}, 64'h0);

      // SA0 (entry0) vs SA1 (entry2) on addr 9 bit 4: lowest index wins
      stage_flt(2'd0, 2'd1, 16'd9, 6'd4);
      idle();
      stage_flt(2'd2, 2'd2, 16'd9, 6'd4);
      idle();
      access(1'b1, 16'd9, 64'h10);
      access(1'b0, 16'd9, 64'h0);
      check("prio_data", rdata, 64'h0);
      check("prio_hit", fault_hit_cnt, 64'd3);
      // A fault on another bit applies alongside
      stage_flt(2'd3, 2'd2, 16'd9, 6'd1);
      idle();
      access(1'b0, 16'd9, 64'h0);
      check("multi_bit_data", rdata, 64'h2);
      check("multi_bit_cnt", read_cnt, 64'd9);

      // Saturation: run read_cnt up to FFFE, then three more reads
      @(negedge clk);
      mem_en = 1'b1; write_read = 1'b0; address = 16'd3;
      repeat (65534 - 9) @(posedge clk);
      #1;
      mem_en = 1'b0;
      check("preload_cnt", read_cnt, 64'hFFFE);
      access(1'b0, 16'd3, 64'h0);
      access(1'b0, 16'd3, 64'h0);
      access(1'b0, 16'd3, 64'h0);
      check("sat_cnt", read_cnt, 64'hFFFF);
      check("sat_hit_unchanged", fault_hit_cnt, 64'd4);

      // Reset asserted while a read is issued: no rvalid, everything cleared
      @(negedge clk);
      mem_en = 1'b1; write_read = 1'b0; address = 16'd3; rst_n = 1'b0;
      @(posedge clk);
      #1;
      mem_en = 1'b0;
      check("rst_mid_rvalid", rvalid, 64'h0);
      check("rst_mid_rdata", rdata, 64'h0);
      check("rst_mid_oor", oor_err, 64'h0);
      check("rst_mid_read_cnt", read_cnt, 64'h0);
      check("rst_mid_hit_cnt", fault_hit_cnt, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fault table cleared, array contents kept
      access(1'b0, 16'd9, 64'h0);
      check("post_rst_table_clr", rdata, 64'h10);
      access(1'b0, 16'd3, 64'h0);
      check("post_rst_mem_kept", rdata, PAT3);
      check("post_rst_cnt", read_cnt, 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
